// File: rtl/z80_regbank_if.sv
// Decoder-to-register-bank bus for z80_regbank.
// Carries write controls, bank swaps, read selects and read data.
interface z80_regbank_if #(
  parameter int WIDTH = 8,
  parameter int PAIRS = 4
);
  localparam int SW = $clog2(PAIRS);
  localparam int DW = 2 * WIDTH;

  logic [SW-1:0] Wr_Sel;
  logic [DW-1:0] Data;
  logic          H_Load;
  logic          L_Load;
  logic          Inc;
  logic          Dec;
  logic          Ex_AF;
  logic          Exx;
  logic [SW-1:0] Rd_A_Sel;
  logic [SW-1:0] Rd_B_Sel;
  logic [DW-1:0] Rd_A;
  logic [DW-1:0] Rd_B;
  logic          Bank_AF;
  logic          Bank_Main;
  logic          Dec_Zero;

  modport master (
    output Wr_Sel, Data,
    output H_Load, L_Load,
    output Inc, Dec,
    output Ex_AF, Exx,
    output Rd_A_Sel, Rd_B_Sel,
    input  Rd_A, Rd_B,
    input  Bank_AF, Bank_Main,
    input  Dec_Zero
  );

  modport slave (
    input  Wr_Sel, Data,
    input  H_Load, L_Load,
    input  Inc, Dec,
    input  Ex_AF, Exx,
    input  Rd_A_Sel, Rd_B_Sel,
    output Rd_A, Rd_B,
    output Bank_AF, Bank_Main,
    output Dec_Zero
  );
endinterface

// File: rtl/z80_regbank.sv
// Bank-switched Z80 register pairs with byte/word write and inc/dec.
// Define Z80_REGBANK_BYPASS_EN to forward same-cycle writes to reads.
module z80_regbank #(
  parameter int WIDTH = 8,
  parameter int PAIRS = 4
) (
  input  logic Clk,
  input  logic Reset,
  z80_regbank_if.slave bus
);
  localparam int SW = $clog2(PAIRS);
  localparam int DW = 2 * WIDTH;
  localparam logic [SW:0] NP = (SW+1)'(PAIRS);

  logic [DW-1:0] r_regs [2][PAIRS];
  logic          r_bank_af;
  logic          r_bank_main;
  logic          r_dec_zero;

  logic          w_wr_ok;
  logic          w_wbank;
  logic          w_load;
  logic          w_step;
  logic          w_wr_en;
  logic          w_dz_next;
  logic [DW-1:0] w_cur;
  logic [DW-1:0] w_next;

  assign w_wr_ok = {1'b0, bus.Wr_Sel} < NP;
  assign w_wbank = (bus.Wr_Sel == '0) ?
                   r_bank_af : r_bank_main;
  assign w_load  = bus.H_Load | bus.L_Load;
  assign w_step  = bus.Inc ^ bus.Dec;
  assign w_wr_en = w_wr_ok & (w_load | w_step);

  always_comb begin
    w_cur  = '0;
    if (w_wr_ok)
      w_cur = r_regs[w_wbank][bus.Wr_Sel];
    w_next = w_cur;
    if (w_load) begin
      if (bus.H_Load)
        w_next[DW-1:WIDTH] = bus.Data[DW-1:WIDTH];
      if (bus.L_Load)
        w_next[WIDTH-1:0] = bus.Data[WIDTH-1:0];
    end else if (w_step) begin
      w_next = bus.Inc ? w_cur + DW'(1)
                       : w_cur - DW'(1);
    end
  end

  assign w_dz_next = w_wr_ok & bus.Dec & ~bus.Inc
                   & ~w_load & (w_cur == DW'(1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int b = 0; b < 2; b++)
        for (int p = 0; p < PAIRS; p++)
          r_regs[b][p] <= '0;
      r_bank_af   <= 1'b0;
      r_bank_main <= 1'b0;
      r_dec_zero  <= 1'b0;
    end else begin
      if (w_wr_en)
        r_regs[w_wbank][bus.Wr_Sel] <= w_next;
      if (bus.Ex_AF)
        r_bank_af <= ~r_bank_af;
      if (bus.Exx)
        r_bank_main <= ~r_bank_main;
      r_dec_zero <= w_dz_next;
    end
  end

  function automatic logic [DW-1:0] f_rd(
    input logic [SW-1:0] sel
  );
    logic b;
    b = (sel == '0) ? r_bank_af : r_bank_main;
    if ({1'b0, sel} >= NP)
      return '0;
`ifdef Z80_REGBANK_BYPASS_EN
    if (w_wr_en && sel == bus.Wr_Sel)
      return w_next;
`endif
    return r_regs[b][sel];
  endfunction

  assign bus.Rd_A      = f_rd(bus.Rd_A_Sel);
  assign bus.Rd_B      = f_rd(bus.Rd_B_Sel);
  assign bus.Bank_AF   = r_bank_af;
  assign bus.Bank_Main = r_bank_main;
  assign bus.Dec_Zero  = r_dec_zero;
endmodule

// File: tb/tb_z80_regbank.sv
// Directed table-driven bench for z80_regbank.
// Covers reset, lanes, inc/dec wrap, bank swaps and bypass timing.
module tb_z80_regbank;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  z80_regbank_if #(.WIDTH(8), .PAIRS(4)) bus ();

  z80_regbank #(.WIDTH(8), .PAIRS(4)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  wsel;
    logic [15:0] data;
    logic        h, l, inc, dec, exaf, exx;
    logic [1:0]  asel, bsel;
    logic [15:0] ea, eb;
    logic        edz, ebaf, ebm;
  } vec_t;

  vec_t tv [$];

  function automatic vec_t mk(
    input logic [1:0] wsel, input logic [15:0] data,
    input logic h, input logic l,
    input logic inc, input logic dec,
    input logic exaf, input logic exx,
    input logic [1:0] asel, input logic [1:0] bsel,
    input logic [15:0] ea, input logic [15:0] eb,
    input logic edz, input logic ebaf, input logic ebm
  );
    vec_t v;
    v.wsel = wsel; v.data = data;
    v.h = h; v.l = l; v.inc = inc; v.dec = dec;
    v.exaf = exaf; v.exx = exx;
    v.asel = asel; v.bsel = bsel;
    v.ea = ea; v.eb = eb;
    v.edz = edz; v.ebaf = ebaf; v.ebm = ebm;
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h want 0x%04h",
               name, act, exp);
    end
  endtask

  task automatic idle();
    bus.H_Load = 1'b0; bus.L_Load = 1'b0;
    bus.Inc = 1'b0; bus.Dec = 1'b0;
    bus.Ex_AF = 1'b0; bus.Exx = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic wr(input logic [1:0] s,
                    input logic [15:0] d);
    bus.Wr_Sel = s; bus.Data = d;
    bus.H_Load = 1'b1; bus.L_Load = 1'b1;
    step();
  endtask

  task automatic swap_both();
    bus.Ex_AF = 1'b1; bus.Exx = 1'b1;
    step();
  endtask

  initial begin
    bus.Wr_Sel = '0; bus.Data = '0;
    bus.Rd_A_Sel = '0; bus.Rd_B_Sel = '0;
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;

    for (int b = 0; b < 2; b++) begin
      for (int p = 0; p < 4; p++)
        wr(2'(p), 16'h1234);
      swap_both();
    end
    swap_both();
    bus.Rd_A_Sel = 2'd2;
    #1 chk("preload", bus.Rd_A, 16'h1234);
    chk("preswap_af", 16'(bus.Bank_AF), 16'h1);

    rst = 1'b1;
    bus.Wr_Sel = 2'd1; bus.Data = 16'hBEEF;
    bus.H_Load = 1'b1; bus.L_Load = 1'b1;
    bus.Ex_AF = 1'b1; bus.Exx = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_baf", 16'(bus.Bank_AF), 16'h0);
    chk("rst_bm", 16'(bus.Bank_Main), 16'h0);
    chk("rst_dz", 16'(bus.Dec_Zero), 16'h0);
    for (int b = 0; b < 2; b++) begin
      for (int p = 0; p < 4; p++) begin
        bus.Rd_A_Sel = 2'(p);
        bus.Rd_B_Sel = 2'(p);
        #1;
        chk($sformatf("rst_a_b%0d_p%0d", b, p),
            bus.Rd_A, 16'h0);
        chk($sformatf("rst_b_b%0d_p%0d", b, p),
            bus.Rd_B, 16'h0);
      end
      swap_both();
    end

    tv.push_back(mk(1,16'hAB55,1,0,0,0,0,0,1,0,16'hAB00,0,0,0,0));
    tv.push_back(mk(1,16'h11CD,0,1,0,0,0,0,1,0,16'hABCD,0,0,0,0));
    tv.push_back(mk(1,16'h0102,1,1,0,0,0,0,1,0,16'h0102,0,0,0,0));
    tv.push_back(mk(3,16'hFFFF,1,1,0,0,0,0,3,1,16'hFFFF,16'h0102,0,0,0));
    tv.push_back(mk(3,16'h0000,0,0,1,0,0,0,3,1,16'h0000,16'h0102,0,0,0));
    tv.push_back(mk(3,16'h0000,0,0,0,1,0,0,3,1,16'hFFFF,16'h0102,0,0,0));
    tv.push_back(mk(1,16'h0001,1,1,0,0,0,0,1,3,16'h0001,16'hFFFF,0,0,0));
    tv.push_back(mk(1,16'h0000,0,0,0,1,0,0,1,3,16'h0000,16'hFFFF,1,0,0));
    tv.push_back(mk(1,16'h0000,0,0,0,0,0,0,1,3,16'h0000,16'hFFFF,0,0,0));
    tv.push_back(mk(1,16'h0042,1,1,0,0,0,0,1,0,16'h0042,0,0,0,0));
    tv.push_back(mk(1,16'h0000,0,0,1,1,0,0,1,0,16'h0042,0,0,0,0));
    tv.push_back(mk(1,16'h0001,1,1,0,0,0,0,1,0,16'h0001,0,0,0,0));
    tv.push_back(mk(1,16'h0000,1,0,0,1,0,0,1,0,16'h0001,0,0,0,0));
    tv.push_back(mk(2,16'h1111,1,1,0,0,0,0,2,0,16'h1111,0,0,0,0));
    tv.push_back(mk(0,16'h7777,1,1,0,0,0,0,2,0,16'h1111,16'h7777,0,0,0));
    tv.push_back(mk(0,16'h0000,0,0,0,0,0,1,2,0,16'h0000,16'h7777,0,0,1));
    tv.push_back(mk(2,16'h2222,1,1,0,0,0,0,2,0,16'h2222,16'h7777,0,0,1));
    tv.push_back(mk(0,16'h0000,0,0,0,0,0,1,2,0,16'h1111,16'h7777,0,0,0));
    tv.push_back(mk(0,16'h0000,0,0,0,0,1,0,2,0,16'h1111,16'h0000,0,1,0));
    tv.push_back(mk(0,16'h0000,0,0,0,0,1,0,2,0,16'h1111,16'h7777,0,0,0));
    tv.push_back(mk(3,16'h5A5A,1,1,0,0,0,1,3,0,16'h0000,16'h7777,0,0,1));
    tv.push_back(mk(0,16'h0000,0,0,0,0,0,1,3,0,16'h5A5A,16'h7777,0,0,0));
    tv.push_back(mk(0,16'h0000,0,0,0,0,1,1,3,0,16'h0000,16'h0000,0,1,1));
    tv.push_back(mk(0,16'h0000,0,0,0,0,1,1,3,0,16'h5A5A,16'h7777,0,0,0));

    foreach (tv[i]) begin
      bus.Wr_Sel = tv[i].wsel; bus.Data = tv[i].data;
      bus.H_Load = tv[i].h; bus.L_Load = tv[i].l;
      bus.Inc = tv[i].inc; bus.Dec = tv[i].dec;
      bus.Ex_AF = tv[i].exaf; bus.Exx = tv[i].exx;
      bus.Rd_A_Sel = tv[i].asel;
      bus.Rd_B_Sel = tv[i].bsel;
      step();
      chk($sformatf("v%0d_rd_a", i), bus.Rd_A, tv[i].ea);
      chk($sformatf("v%0d_rd_b", i), bus.Rd_B, tv[i].eb);
      chk($sformatf("v%0d_dz", i),
          16'(bus.Dec_Zero), 16'(tv[i].edz));
      chk($sformatf("v%0d_baf", i),
          16'(bus.Bank_AF), 16'(tv[i].ebaf));
      chk($sformatf("v%0d_bm", i),
          16'(bus.Bank_Main), 16'(tv[i].ebm));
    end

    wr(2'd1, 16'h3300);
    bus.Rd_A_Sel = 2'd1;
    bus.Wr_Sel = 2'd1; bus.Data = 16'h00EE;
    bus.L_Load = 1'b1;
    #1;
`ifdef Z80_REGBANK_BYPASS_EN
    chk("bypass_same", bus.Rd_A, 16'h33EE);
`else
    chk("bypass_same", bus.Rd_A, 16'h3300);
`endif
    step();
    chk("bypass_next", bus.Rd_A, 16'h33EE);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
